operand_loader: RTL and testbench

Serial operand front-end for the four-operand select/compute stage. Accepts a byte stream over a valid/ready handshake, assembles one frame of four operands (A, B, C, D) plus a 2-bit select code, and presents the complete frame with a valid/ready handshake to the downstream stage. The downstream stage consumes A, B, C, D and select directly. Each frame is held stable until the downstream stage accepts it.

---
 rtl/operand_loader.sv | 122 ++++++++++++
 tb/tb_operand_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader: serial operand front-end for the four-operand select/compute stage.
// Assembles one frame from a byte stream: operand bytes A, B, C, D, then a select byte.
// The completed frame is held stable on A..D/select/sel_err while out_valid is high,
// until the downstream stage accepts it with out_ready.
module operand_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       select,
  output logic             sel_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [2:0] {
    LD_A   = 3'd0,
    LD_B   = 3'd1,
    LD_C   = 3'd2,
    LD_D   = 3'd3,
    LD_SEL = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic xfer;
  logic handoff;

  // in_ready/out_valid are pure state decodes, so both qualifiers are free of
  // combinational input-to-output paths.
  assign xfer    = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one step per byte transfer, leave HOLD on handoff; clear wins.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LD_A;
    end else begin
      unique case (state)
        LD_A:    if (xfer)    state_nxt = LD_B;
        LD_B:    if (xfer)    state_nxt = LD_C;
        LD_C:    if (xfer)    state_nxt = LD_D;
        LD_D:    if (xfer)    state_nxt = LD_SEL;
        LD_SEL:  if (xfer)    state_nxt = HOLD;
        HOLD:    if (handoff) state_nxt = LD_A;
        default:              state_nxt = LD_A;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state == HOLD) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  // Operand and select registers: written by the transfer of their own state, zeroed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A       <= '0;
      B       <= '0;
      C       <= '0;
      D       <= '0;
      select  <= '0;
      sel_err <= 1'b0;
    end else if (clear) begin
      A       <= '0;
      B       <= '0;
      C       <= '0;
      D       <= '0;
      select  <= '0;
      sel_err <= 1'b0;
    end else if (xfer) begin
      unique case (state)
        LD_A:   A <= in_data;
        LD_B:   B <= in_data;
        LD_C:   C <= in_data;
        LD_D:   D <= in_data;
        LD_SEL: begin
          select  <= in_data[1:0];
          sel_err <= |in_data[WIDTH-1:2];
        end
        default: ;
      endcase
    end
  end

  // Handoff counter, wraps modulo 256; a clear in the same cycle suppresses the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!clear && handoff) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Testbench for operand_loader: table of frame vectors plus hand-written corner sequences.
// Expected frames are pushed to a scoreboard queue as bytes are driven and popped when
// out_valid is observed. Inputs change and outputs are sampled on the falling edge.
module tb_operand_loader;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A, B, C, D;
  logic [1:0]       select;
  logic             sel_err;
  logic [7:0]       frame_cnt;

  operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .select    (select),
    .sel_err   (sel_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:4][7:0] b;
    logic [1:0]      gap;
    logic [7:0]      ea, eb, ec, ed;
    logic [1:0]      esel;
    logic            eerr;
  } vec_t;

  typedef struct packed {
    logic [7:0] a, b, c, d;
    logic [1:0] sel;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  vec_t       vecs[6];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Drive five bytes starting at a falling edge; gap idle cycles between bytes.
  task automatic send_frame(input logic [0:4][7:0] b, input logic [1:0] gap);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 4) repeat (int'(gap)) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_vals(input string tag, input exp_t e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".A"},         32'(A),         32'(e.a));
    check({tag, ".B"},         32'(B),         32'(e.b));
    check({tag, ".C"},         32'(C),         32'(e.c));
    check({tag, ".D"},         32'(D),         32'(e.d));
    check({tag, ".select"},    32'(select),    32'(e.sel));
    check({tag, ".sel_err"},   32'(sel_err),   32'(e.err));
  endtask

  // Pop the oldest expected frame and compare against the presented frame.
  task automatic check_frame(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s.scoreboard: got frame, want none queued", tag);
    end else begin
      e = sbq.pop_front();
      check_vals(tag, e);
    end
  endtask

  task automatic do_handoff(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check({tag, ".cnt"},      32'(frame_cnt), 32'(exp_cnt));
    check({tag, ".ov_fall"},  32'(out_valid), 32'd0);
    check({tag, ".ir_rise"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    exp_t       e;
    logic [7:0] k;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_cnt = '0;

    vecs[0] = '{b: {8'h11, 8'h22, 8'h33, 8'h44, 8'h02}, gap: 2'd0,
                ea: 8'h11, eb: 8'h22, ec: 8'h33, ed: 8'h44, esel: 2'd2, eerr: 1'b0};
    vecs[1] = '{b: {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF1}, gap: 2'd0,
                ea: 8'hAA, eb: 8'hBB, ec: 8'hCC, ed: 8'hDD, esel: 2'd1, eerr: 1'b1};
    vecs[2] = '{b: {8'h01, 8'h02, 8'h03, 8'h04, 8'h03}, gap: 2'd0,
                ea: 8'h01, eb: 8'h02, ec: 8'h03, ed: 8'h04, esel: 2'd3, eerr: 1'b0};
    vecs[3] = '{b: {8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h04}, gap: 2'd2,
                ea: 8'h5A, eb: 8'hA5, ec: 8'hFF, ed: 8'h00, esel: 2'd0, eerr: 1'b1};
    vecs[4] = '{b: {8'h80, 8'h7F, 8'h01, 8'hFE, 8'h00}, gap: 2'd1,
                ea: 8'h80, eb: 8'h7F, ec: 8'h01, ed: 8'hFE, esel: 2'd0, eerr: 1'b0};
    vecs[5] = '{b: {8'hC3, 8'h3C, 8'h96, 8'h69, 8'h82}, gap: 2'd3,
                ea: 8'hC3, eb: 8'h3C, ec: 8'h96, ed: 8'h69, esel: 2'd2, eerr: 1'b1};

    // Reset state, including an attempted transfer while reset is asserted
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    check("rst.A",         32'(A),         32'd0);
    check("rst.select",    32'(select),    32'd0);
    check("rst.sel_err",   32'(sel_err),   32'd0);
    check("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames with a held consumer, then a single handoff each
    for (int i = 0; i < 6; i++) begin
      sbq.push_back('{a: vecs[i].ea, b: vecs[i].eb, c: vecs[i].ec, d: vecs[i].ed,
                      sel: vecs[i].esel, err: vecs[i].eerr});
      send_frame(vecs[i].b, vecs[i].gap);
      check_frame($sformatf("vec%0d", i));
      do_handoff($sformatf("vec%0d", i));
    end

    // Stalled consumer: frame held 10 cycles, a stray byte in HOLD is refused
    e = '{a: 8'h11, b: 8'h22, c: 8'h33, d: 8'h44, sel: 2'd2, err: 1'b0};
    sbq.push_back(e);
    send_frame({8'h11, 8'h22, 8'h33, 8'h44, 8'h02}, 2'd0);
    check_frame("stall0");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      in_data  = 8'h99;
      @(negedge clk);
      check_vals($sformatf("stall%0d", i + 1), e);
    end
    in_valid = 1'b0;
    do_handoff("stall");
    check("stall.A_kept", 32'(A), 32'h11);

    // Clear after three bytes, then a full frame must start from LD_A
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr.A",         32'(A),         32'd0);
    check("clr.B",         32'(B),         32'd0);
    check("clr.C",         32'(C),         32'd0);
    check("clr.D",         32'(D),         32'd0);
    check("clr.out_valid", 32'(out_valid), 32'd0);
    check("clr.in_ready",  32'(in_ready),  32'd1);
    check("clr.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    sbq.push_back('{a: 8'h01, b: 8'h02, c: 8'h03, d: 8'h04, sel: 2'd1, err: 1'b1});
    send_frame({8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 2'd0);
    check_frame("clr_next");
    do_handoff("clr_next");

    // Clear in HOLD together with out_ready: no handoff counted
    send_frame({8'h10, 8'h20, 8'h30, 8'h40, 8'h01}, 2'd0);
    check("clrh.ov_before", 32'(out_valid), 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    check("clrh.out_valid", 32'(out_valid), 32'd0);
    check("clrh.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("clrh.A",         32'(A),         32'd0);
    check("clrh.select",    32'(select),    32'd0);

    // Asynchronous reset mid-frame, away from any clock edge
    in_valid = 1'b1; in_data = 8'h61;
    @(negedge clk);
    in_data = 8'h62;
    @(negedge clk);
    in_data = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    check("arst.A",         32'(A),         32'd0);
    check("arst.B",         32'(B),         32'd0);
    check("arst.frame_cnt", 32'(frame_cnt), 32'd0);
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    check("arst.A_hold",    32'(A),         32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);

    // 256 back-to-back frames with out_ready held high; frame_cnt wraps to 0
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      sbq.push_back('{a: k, b: ~k, c: k + 8'd1, d: k ^ 8'h5A, sel: k[1:0], err: k[7]});
      send_frame({k, ~k, k + 8'd1, k ^ 8'h5A, {1'b0, k[7], 4'b0000, k[1:0]}}, 2'd0);
      check_frame($sformatf("wrap%0d", i));
      if (i == 255) check("wrap.cnt255", 32'(frame_cnt), 32'd255);
      @(negedge clk);
      exp_cnt++;
      check($sformatf("wrap%0d.ov_fall", i), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    check("wrap.cnt0",     32'(frame_cnt), 32'd0);
    check("wrap.cnt_model", 32'(frame_cnt), 32'(exp_cnt));
    check("sb.empty",      32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound in case the design stalls the stimulus
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
